// File: rtl/video_mode_select.sv
// Video mode source: debounced front-panel button cycles 480i/720p/1080p, a
// ready/valid port sets explicit codes, and every change is held HOLD_CYCLES.
`ifndef MODE_480i
`define MODE_480i 8'h01
`endif
`ifndef MODE_720p
`define MODE_720p 8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif

module video_mode_select #(
  parameter int         DEBOUNCE_CYCLES = 540000,
  parameter int         HOLD_CYCLES     = 16,
  parameter logic [7:0] INITIAL_MODE    = `MODE_1080p
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button_n,
  input  logic       req_valid,
  input  logic [7:0] req_mode,
  output logic       req_ready,
  output logic [7:0] mode_code,
  output logic [1:0] mode_index,
  output logic       mode_changed
);

  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // req_ready is high only in IDLE and depends on the state register alone.

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

  function automatic logic [7:0] code_of_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    code_of_idx = `MODE_480i;
      2'd1:    code_of_idx = `MODE_720p;
      default: code_of_idx = `MODE_1080p;
    endcase
  endfunction

  function automatic logic [1:0] idx_of_code(input logic [7:0] code);
    if (code == `MODE_480i)      idx_of_code = 2'd0;
    else if (code == `MODE_720p) idx_of_code = 2'd1;
    else                         idx_of_code = 2'd2;
  endfunction

  function automatic logic is_known(input logic [7:0] code);
    is_known = (code == `MODE_480i) || (code == `MODE_720p) || (code == `MODE_1080p);
  endfunction

  localparam logic [1:0] INIT_IDX = idx_of_code(INITIAL_MODE);

  // Button synchroniser and debounce
  logic        sync1, sync2, stable, press_evt;
  logic [19:0] deb_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      stable    <= 1'b1;
      deb_cnt   <= '0;
      press_evt <= 1'b0;
    end else begin
      sync1     <= button_n;
      sync2     <= sync1;
      press_evt <= 1'b0;
      if (sync2 == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        stable    <= sync2;
        deb_cnt   <= '0;
        press_evt <= ~sync2;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

  // Mode FSM
  state_t     state, state_d;
  logic [7:0] hold_cnt, hold_d;
  logic       pending, pend_d;
  logic [1:0] idx_d, next_idx;
  logic       chg_d, req_change;

  assign req_ready  = (state == IDLE);
  assign next_idx   = (mode_index == 2'd2) ? 2'd0 : mode_index + 2'd1;
  assign req_change = is_known(req_mode) && (req_mode != mode_code);

  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    pend_d  = pending;
    idx_d   = mode_index;
    chg_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_change) begin
          // Request wins; a simultaneous press waits out the hold window.
          idx_d   = idx_of_code(req_mode);
          chg_d   = 1'b1;
          state_d = HOLD;
          hold_d  = '0;
          pend_d  = pending | press_evt;
        end else if (press_evt || pending) begin
          idx_d   = next_idx;
          chg_d   = 1'b1;
          state_d = HOLD;
          hold_d  = '0;
          pend_d  = 1'b0;
        end
      end
      HOLD: begin
        if (press_evt) pend_d = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      pending      <= 1'b0;
      mode_index   <= INIT_IDX;
      mode_code    <= code_of_idx(INIT_IDX);
      mode_changed <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_d;
      pending      <= pend_d;
      mode_index   <= idx_d;
      mode_code    <= code_of_idx(idx_d);
      mode_changed <= chg_d;
    end
  end

endmodule

// File: tb/tb_video_mode_select.sv
// Directed and randomized bench for video_mode_select (DEBOUNCE=8, HOLD=4).
`ifndef MODE_480i
`define MODE_480i 8'h01
`endif
`ifndef MODE_720p
`define MODE_720p 8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif

module tb_video_mode_select;

  localparam int DEB  = 8;
  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset_n, button_n, req_valid, req_ready, mode_changed;
  logic [7:0] req_mode, mode_code;
  logic [1:0] mode_index;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;

  logic [7:0] codes [3];
  int m_idx, m_last, new_idx;
  logic exp_chg, m_ready_before;

  video_mode_select #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .INITIAL_MODE(`MODE_1080p)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .button_n(button_n),
    .req_valid(req_valid),
    .req_mode(req_mode),
    .req_ready(req_ready),
    .mode_code(mode_code),
    .mode_index(mode_index),
    .mode_changed(mode_changed)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    if (mode_changed === 1'b1) pulse_cnt++;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic int idx_of(input logic [7:0] code);
    idx_of = -1;
    for (int i = 0; i < 3; i++) if (codes[i] == code) idx_of = i;
  endfunction

  initial begin
    codes[0] = `MODE_480i;
    codes[1] = `MODE_720p;
    codes[2] = `MODE_1080p;
    button_n  = 1'b1;
    req_valid = 1'b0;
    req_mode  = 8'h00;

    // 1. reset values
    do_reset();
    check("rst_code", int'(mode_code), int'(codes[2]));
    check("rst_idx", int'(mode_index), 2);
    check("rst_chg", int'(mode_changed), 0);
    check("rst_ready", int'(req_ready), 1);

    // 2. button wrap 1080p -> 480i -> 720p; release gives nothing
    pulse_cnt = 0;
    button_n = 1'b0;
    repeat (20) tick();
    check("btn1_pulses", pulse_cnt, 1);
    check("btn1_idx", int'(mode_index), 0);
    check("btn1_code", int'(mode_code), int'(codes[0]));
    button_n = 1'b1;
    repeat (20) tick();
    check("release_pulses", pulse_cnt, 1);
    pulse_cnt = 0;
    button_n = 1'b0;
    repeat (20) tick();
    check("btn2_pulses", pulse_cnt, 1);
    check("btn2_idx", int'(mode_index), 1);
    check("btn2_code", int'(mode_code), int'(codes[1]));
    button_n = 1'b1;
    repeat (20) tick();

    // 3. bounce rejection
    pulse_cnt = 0;
    repeat (6) begin
      button_n = 1'b0;
      repeat (5) tick();
      button_n = 1'b1;
      repeat (3) tick();
    end
    repeat (20) tick();
    check("bounce_pulses", pulse_cnt, 0);
    check("bounce_code", int'(mode_code), int'(codes[1]));

    // 4. request path from 1080p
    do_reset();
    req_valid = 1'b1;
    req_mode  = codes[1];
    tick();
    req_valid = 1'b0;
    check("req_code", int'(mode_code), int'(codes[1]));
    check("req_chg", int'(mode_changed), 1);
    check("req_ready0", int'(req_ready), 0);
    tick();
    check("req_chg_1cyc", int'(mode_changed), 0);
    check("req_ready1", int'(req_ready), 0);
    tick();
    check("req_ready2", int'(req_ready), 0);
    tick();
    check("req_ready3", int'(req_ready), 0);
    tick();
    check("req_ready_back", int'(req_ready), 1);
    pulse_cnt = 0;
    req_valid = 1'b1;
    req_mode  = 8'hFF;
    tick();
    req_valid = 1'b0;
    check("bad_code", int'(mode_code), int'(codes[1]));
    check("bad_chg", int'(mode_changed), 0);
    check("bad_ready", int'(req_ready), 1);

    // 5. collision: request and press event meet at edge 2 + DEB + 1
    req_valid = 1'b1;
    req_mode  = codes[2];
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    check("col_pre_code", int'(mode_code), int'(codes[2]));
    pulse_cnt = 0;
    button_n = 1'b0;
    repeat (2 + DEB) tick();
    check("col_no_early", int'(mode_code), int'(codes[2]));
    req_valid = 1'b1;
    req_mode  = codes[0];
    tick();
    req_valid = 1'b0;
    check("col_req_code", int'(mode_code), int'(codes[0]));
    check("col_req_chg", int'(mode_changed), 1);
    repeat (HOLD) tick();
    check("col_hold_code", int'(mode_code), int'(codes[0]));
    check("col_idle_ready", int'(req_ready), 1);
    tick();
    check("col_pend_code", int'(mode_code), int'(codes[1]));
    check("col_pend_chg", int'(mode_changed), 1);
    button_n = 1'b1;
    repeat (20) tick();
    check("col_pulses", pulse_cnt, 2);

    // 6. reset while HOLD has a pending press
    button_n = 1'b0;
    repeat (DEB) tick();
    req_valid = 1'b1;
    req_mode  = codes[0];
    tick();
    req_valid = 1'b0;
    check("mid_code", int'(mode_code), int'(codes[0]));
    repeat (2) tick();
    reset_n  = 1'b0;
    button_n = 1'b1;
    #1;
    check("async_code", int'(mode_code), int'(codes[2]));
    check("async_idx", int'(mode_index), 2);
    check("async_chg", int'(mode_changed), 0);
    check("async_ready", int'(req_ready), 1);
    repeat (3) tick();
    reset_n = 1'b1;
    pulse_cnt = 0;
    repeat (20) tick();
    check("no_pending_pulses", pulse_cnt, 0);
    check("no_pending_code", int'(mode_code), int'(codes[2]));

    // 7. randomized request traffic against a timing model
    m_idx  = 2;
    m_last = cyc - 100;
    for (int n = 0; n < 300; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) < 3) req_mode = codes[$urandom_range(0, 2)];
      else req_mode = 8'($urandom_range(0, 255));
      m_ready_before = ((cyc - m_last) >= HOLD);
      tick();
      exp_chg = 1'b0;
      new_idx = idx_of(req_mode);
      if (m_ready_before && req_valid && new_idx >= 0 && new_idx != m_idx) begin
        m_idx   = new_idx;
        m_last  = cyc;
        exp_chg = 1'b1;
      end
      check("rnd_code", int'(mode_code), int'(codes[m_idx]));
      check("rnd_idx", int'(mode_index), m_idx);
      check("rnd_chg", int'(mode_changed), int'(exp_chg));
      check("rnd_ready", int'(req_ready), int'((cyc - m_last) >= HOLD));
    end
    req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
